// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared defaults and operation encoding for the pipelined ripple-carry adder
package rca_pkg;

    localparam int RCA_N_DEF      = 16;
    localparam int RCA_STAGES_DEF = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational W-bit ripple-carry chunk with carry into the top bit exposed
module rca_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic c;

    // Bit-serial ripple; the carry entering the top bit is kept for signed overflow.
    always_comb begin
        c     = ci;
        s     = '0;
        c_msb = ci;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                c_msb = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - STAGES-deep pipelined ripple-carry add/sub with valid/ready; RCA_OVF_EN adds the ovf port
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int N      = RCA_N_DEF,
    parameter int STAGES = RCA_STAGES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef RCA_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int W = N / STAGES;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
        $error("pipelined_rca: STAGES=%0d must be in 1..N and divide N=%0d", STAGES, N);
    end

    // Stage state: valid, partial sum (low chunks filled so far), chunk carry,
    // and the not-yet-consumed operand chunks shifted down so the next chunk sits at bit 0.
    logic [STAGES-1:0] v_q, v_d;
    logic [N-1:0]      sum_q   [STAGES];
    logic [N-1:0]      sum_d   [STAGES];
    logic [N-1:0]      opa_q   [STAGES];
    logic [N-1:0]      opa_d   [STAGES];
    logic [N-1:0]      opb_q   [STAGES];
    logic [N-1:0]      opb_d   [STAGES];
    logic              carry_q [STAGES];
    logic              carry_d [STAGES];

    // What each stage would load: from the input port for stage 0, else from the stage before.
    logic              v_up    [STAGES];
    logic [N-1:0]      sum_up  [STAGES];
    logic [N-1:0]      opa_up  [STAGES];
    logic [N-1:0]      opb_up  [STAGES];
    logic              c_up    [STAGES];

    logic [W-1:0]      ch_a    [STAGES];
    logic [W-1:0]      ch_b    [STAGES];
    logic [W-1:0]      ch_s    [STAGES];
    logic              ch_co   [STAGES];
    logic              ch_msb  [STAGES];

    logic [STAGES:0]   rdy;
    op_e               op_in;
    logic [N-1:0]      b_in;
    logic              c_in;

    // Subtract is a + ~b + ~cin, so invert b and the carry-in once at the input.
    always_comb begin
        op_in = sub ? OP_SUB : OP_ADD;
        b_in  = (op_in == OP_SUB) ? ~b : b;
        c_in  = (op_in == OP_SUB) ? ~cin : cin;
    end

    // Ready ripples back from the consumer: a stage may load when empty or when the next stage moves.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k + 1];
        end
    end

    assign in_ready = rdy[0];

    // Gather upstream values and present the current chunk to each stage's adder.
    always_comb begin
        v_up[0]   = in_valid;
        sum_up[0] = '0;
        opa_up[0] = a;
        opb_up[0] = b_in;
        c_up[0]   = c_in;
        for (int k = 1; k < STAGES; k++) begin
            v_up[k]   = v_q[k - 1];
            sum_up[k] = sum_q[k - 1];
            opa_up[k] = opa_q[k - 1];
            opb_up[k] = opb_q[k - 1];
            c_up[k]   = carry_q[k - 1];
        end
        for (int k = 0; k < STAGES; k++) begin
            ch_a[k] = opa_up[k][W-1:0];
            ch_b[k] = opb_up[k][W-1:0];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        rca_chunk #(
            .W (W)
        ) u_chunk (
            .a     (ch_a[k]),
            .b     (ch_b[k]),
            .ci    (c_up[k]),
            .s     (ch_s[k]),
            .co    (ch_co[k]),
            .c_msb (ch_msb[k])
        );
    end

    // Advance a stage when ready; only capture data when a real beat arrives so stalls and bubbles hold.
    always_comb begin
        v_d = v_q;
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k]   = sum_q[k];
            opa_d[k]   = opa_q[k];
            opb_d[k]   = opb_q[k];
            carry_d[k] = carry_q[k];
            if (rdy[k]) begin
                v_d[k] = v_up[k];
                if (v_up[k]) begin
                    sum_d[k]            = sum_up[k];
                    sum_d[k][k*W +: W]  = ch_s[k];
                    carry_d[k]          = ch_co[k];
                    opa_d[k]            = opa_up[k] >> W;
                    opb_d[k]            = opb_up[k] >> W;
                end
            end
        end
    end

    // Stage registers; reset discards every in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k]   <= '0;
                opa_q[k]   <= '0;
                opb_q[k]   <= '0;
                carry_q[k] <= 1'b0;
            end
        end else begin
            v_q     <= v_d;
            sum_q   <= sum_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];

`ifdef RCA_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow from the top chunk: carry into MSB differs from carry out of MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (rdy[STAGES-1] && v_up[STAGES-1]) begin
            ovf_d = ch_co[STAGES-1] ^ ch_msb[STAGES-1];
        end
    end

    // Overflow flag registered alongside the final sum chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// tb/tb_pipelined_rca.sv - self-checking bench for pipelined_rca (N=16, STAGES=4)
module tb_pipelined_rca;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] sum;
    logic        cout;
`ifdef RCA_OVF_EN
    logic        ovf;
`endif

    pipelined_rca #(
        .N      (16),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef RCA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    bit   last_acc;
    bit   last_drn;
    logic [15:0] last_sum;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic s);
        res_t r;
        int   ux, uy, u, sx, sy, rs;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            u   = ux + uy + int'(ci);
            r.c = (u > 65535);
            rs  = sx + sy + int'(ci);
        end else begin
            u   = ux - uy - int'(ci);
            r.c = (ux >= uy + int'(ci));
            rs  = sx - sy - int'(ci);
        end
        r.s = 16'(u);
        r.o = (rs > 32767) || (rs < -32768);
        return r;
    endfunction

    // One clock with scoreboard: inputs already driven; sample, take the edge, return at negedge.
    task automatic cycle();
        bit   acc, drn;
        res_t got, e;
        #1;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        got.s = sum;
        got.c = cout;
`ifdef RCA_OVF_EN
        got.o = ovf;
`else
        got.o = 1'b0;
`endif
        if (drn) begin
            last_sum = got.s;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out got=%0h expected=none", got.s);
            end else begin
                e = exp_q.pop_front();
                chk("sb_sum", got.s, e.s);
                chk("sb_cout", got.c, e.c);
`ifdef RCA_OVF_EN
                chk("sb_ovf", got.o, e.o);
`endif
            end
        end
        if (acc) exp_q.push_back(model(a, b, cin, sub));
        last_acc = acc;
        last_drn = drn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_beat();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    // Single beat into an empty pipe: check the exact edge it appears and its value.
    task automatic run_vec(input vec_t v, input int i);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", i), in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d_lat_e0", i), out_valid, 0);
        for (int n = 1; n <= 2; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_lat_e%0d", i, n), out_valid, 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_valid_e3", i), out_valid, 1);
        chk($sformatf("v%0d_sum", i), sum, v.e_sum);
        chk($sformatf("v%0d_cout", i), cout, v.e_cout);
`ifdef RCA_OVF_EN
        chk($sformatf("v%0d_ovf", i), ovf, v.e_ovf);
`endif
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_drained", i), out_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $finish;
    end

    initial begin
        vec_t        vecs [9];
        logic [15:0] bpa [6];
        logic [15:0] bpb [6];
        int          idx, drains, first_c, last_c, cyc;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef RCA_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Directed table with exact latency
        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Backpressure: only four beats fit while the consumer stalls
        for (int i = 0; i < 6; i++) begin
            bpa[i] = 16'($urandom);
            bpb[i] = 16'($urandom);
        end
        cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin a = bpa[idx]; b = bpb[idx]; end
            cycle();
            if (last_acc) idx++;
        end
        chk("bp_accepts", idx, 4);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid_held", out_valid, 1);
        out_ready = 1'b1;
        drains = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 20 && drains < 6; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin a = bpa[idx]; b = bpb[idx]; end
            cycle();
            if (last_acc) idx++;
            if (last_drn) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                drains++;
            end
        end
        in_valid = 1'b0;
        chk("bp_drains", drains, 6);
        chk("bp_one_per_cycle", last_c - first_c, 5);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Bubble collapse: a lone beat then three more behind a stalled consumer
        out_ready = 1'b1;
        in_valid = 1'b1;
        rand_beat();
        cycle();
        chk("bub_first_acc", last_acc, 1);
        in_valid = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            rand_beat();
            cycle();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        chk("bub_accepts", idx, 3);
        chk("bub_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk($sformatf("bub_drain%0d", c), last_drn, 1);
        end
        cycle();
        chk("bub_empty_after", last_drn, 0);
        chk("bub_queue_empty", exp_q.size(), 0);

        // Random traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_beat();
            if (c % 50 == 0) begin a = 16'hFFFF; b = 16'h0000; end
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 30) begin
            cycle();
            cyc++;
        end
        chk("rand_drain_empty", exp_q.size(), 0);

        // Reset with beats in flight
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            a = 16'h4000 + 16'(c);
            b = 16'h0F0F;
            cin = 1'b1; sub = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("mid_out_valid_before", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_sum", sum, 0);
        chk("mid_cout", cout, 0);
`ifdef RCA_OVF_EN
        chk("mid_ovf", ovf, 0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        drains = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (last_drn) drains++;
        end
        chk("post_rst_drains", drains, 1);
        chk("post_rst_sum", last_sum, 16'h2345);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
